// File: rtl/div_seq_pkg.sv
// div_pkg: shared types and helpers for the sequential restoring divider.
//   state_t : FSM encoding (idle, iterating, result-valid)
//   cnt_w   : width of the iteration counter, large enough to hold N itself
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: start/done handshake and operand/result bundle of div_seq.
//   start        : request, honoured only while busy is low
//   a, b         : dividend / divisor, captured on the accepting edge
//   busy         : high while the divider iterates
//   done         : one-cycle pulse, q/r/div_by_zero valid from this cycle on
//   q, r         : quotient / remainder, held until the next result
//   div_by_zero  : set together with done when b was zero
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0 (idle or the done cycle). Exactly one done pulse follows every
// accepted request unless reset intervenes; start seen while busy=1 is
// ignored and the operands are not resampled.
interface div_seq_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_by_zero
  );
endinterface

// File: rtl/div_seq_step.sv
// div_step: one restoring-division iteration (purely combinational).
//   rem_in       : partial remainder before this step
//   dividend_msb : next dividend bit shifted into the remainder
//   divisor      : divisor
//   rem_out      : partial remainder after trial subtract / restore
//   q_bit        : quotient bit produced by this step
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] rem_in,
  input  logic         dividend_msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N-1:0] rem_sh;
  logic [N:0]   trial;
  logic         unused_rem_msb;

  // After k steps the partial remainder is at most the top k dividend bits,
  // so its MSB can only be set after the final step; it is never shifted out.
  assign unused_rem_msb = rem_in[N-1];

  assign rem_sh  = {rem_in[N-2:0], dividend_msb};
  // Extra top bit acts as the borrow: set means the trial went negative.
  assign trial   = {1'b0, rem_sh} - {1'b0, divisor};
  assign q_bit   = ~trial[N];
  assign rem_out = q_bit ? trial[N-1:0] : rem_sh;

endmodule

// File: rtl/div_seq.sv
// div_seq: sequential unsigned restoring divider, one quotient bit per clock.
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset, aborts any operation
//   bus         : div_seq_if slave (start/a/b in, busy/done/q/r/div_by_zero out)
//   state_dbg_o : current FSM state for observation
// Latency: start accepted at edge 0 -> busy cycles 1..N -> done in cycle N+1.
// A zero divisor skips the iterations and signals done in cycle 1.
module div_seq
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       reset,
  div_seq_if.slave   bus,
  output state_t     state_dbg_o
);

  localparam int CW = cnt_w(N);

  state_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] dvd_q, dvd_d;   // dividend, shifted left each step
  logic [N-1:0] dvs_q, dvs_d;   // divisor captured at accept
  logic [N-1:0] rem_q, rem_d;   // partial remainder
  logic [N-1:0] quo_q, quo_d;   // quotient being assembled
  logic [N-1:0] q_q, q_d;       // published quotient
  logic [N-1:0] r_q, r_d;       // published remainder
  logic         dbz_q, dbz_d;

  logic [N-1:0] step_rem;
  logic         step_qbit;

  div_step #(.N(N)) u_step (
    .rem_in      (rem_q),
    .dividend_msb(dvd_q[N-1]),
    .divisor     (dvs_q),
    .rem_out     (step_rem),
    .q_bit       (step_qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      // The done cycle accepts a new request exactly like idle, which gives
      // back-to-back operation without an intervening idle cycle.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          dvd_d = bus.a;
          dvs_d = bus.b;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CW'(N);
          if (bus.b == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = bus.a;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[N-2:0], step_qbit};
        dvd_d = {dvd_q[N-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          q_d     = {quo_q[N-2:0], step_qbit};
          r_d     = step_rem;
          dbz_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.q           = q_q;
  assign bus.r           = r_q;
  assign bus.div_by_zero = dbz_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq (N=4): timing, handshake, divide-by-zero,
// asynchronous reset and an exhaustive back-to-back sweep of all operands.
module tb_div_seq;
  import div_pkg::*;

  localparam int N = 4;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  int vectors    = 0;
  int miscompares = 0;
  int done_cnt   = 0;
  int starts     = 0;
  int snap;

  div_seq_if #(.N(N)) bus ();

  div_seq #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .state_dbg_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    starts++;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; busy must be high in every cycle before it.
  task automatic wait_done(input int exp_lat, input string tag);
    int lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy@done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_res(input string tag, input int eq, input int er, input int edbz);
    check({tag, " q"}, 32'(bus.q), 32'(eq));
    check({tag, " r"}, 32'(bus.r), 32'(er));
    check({tag, " dbz"}, 32'(bus.div_by_zero), 32'(edbz));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // stimulus
  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    idle(3);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check_res("reset", 0, 0, 0);
    check("reset state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    idle(2);

    // 13/3: busy cycles 1-4, done in cycle 5, result held afterwards
    launch(4'd13, 4'd3);
    wait_done(5, "13/3");
    check_res("13/3", 4, 1, 0);
    idle(1);
    check("13/3 done pulse", 32'(bus.done), 32'd0);
    idle(2);
    check_res("13/3 held", 4, 1, 0);

    launch(4'd7, 4'd9);
    wait_done(5, "7/9");
    check_res("7/9", 0, 7, 0);
    idle(2);

    launch(4'd15, 4'd1);
    wait_done(5, "15/1");
    check_res("15/1", 15, 0, 0);
    idle(2);

    // divide by zero fast path, then a normal divide clears the flag
    launch(4'd9, 4'd0);
    wait_done(1, "9/0");
    check_res("9/0", 15, 9, 1);
    idle(2);
    launch(4'd8, 4'd2);
    wait_done(5, "8/2");
    check_res("8/2", 4, 0, 0);
    idle(2);

    // start held through RUN with operands changed: original result, one done
    snap = done_cnt;
    bus.start = 1'b1;
    bus.a     = 4'd13;
    bus.b     = 4'd3;
    starts++;
    @(posedge clk);
    #1;
    bus.a = 4'd2;
    bus.b = 4'd1;
    wait_done(5, "held start");
    bus.start = 1'b0;
    check_res("held start", 4, 1, 0);
    idle(4);
    check("held start dones", 32'(done_cnt - snap), 32'd1);
    check("held start state", 32'(dbg_state), 32'(S_IDLE));

    // back-to-back: new start in the done cycle
    launch(4'd13, 4'd3);
    wait_done(5, "b2b first");
    check_res("b2b first", 4, 1, 0);
    launch(4'd7, 4'd2);
    wait_done(5, "b2b second");
    check_res("b2b second", 3, 1, 0);
    idle(2);

    // asynchronous reset in cycle 2 of 13/3
    snap = done_cnt;
    launch(4'd13, 4'd3);
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    check("async rst busy", 32'(bus.busy), 32'd0);
    check("async rst done", 32'(bus.done), 32'd0);
    check_res("async rst", 0, 0, 0);
    check("async rst state", 32'(dbg_state), 32'(S_IDLE));
    starts--;
    @(negedge clk);
    reset = 1'b0;
    idle(8);
    check("no done after reset", 32'(done_cnt - snap), 32'd0);
    launch(4'd6, 4'd4);
    wait_done(5, "6/4");
    check_res("6/4", 1, 2, 0);

    // exhaustive, back-to-back
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        launch(4'(ai), 4'(bi));
        if (bi == 0) begin
          wait_done(1, "sweep");
          check_res("sweep b=0", 15, ai, 1);
        end else begin
          wait_done(5, "sweep");
          check_res("sweep", ai / bi, ai % bi, 0);
        end
      end
    end
    idle(3);
    check("one done per start", 32'(done_cnt), 32'(starts));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
Sequential unsigned restoring divider: N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.
Inverse operation of the team's combinational 4x4 multiplier; computes one quotient bit per clock.
Start/done handshake for use by a controlling FSM or testbench.
Default N=4 pairs with the existing 4-bit datapath.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  N  dividend (unsigned), sampled with accepted start
b  input  N  divisor (unsigned), sampled with accepted start
busy  output  1  high while iterating (RUN)
done  output  1  single-cycle pulse; q/r/div_by_zero valid
q  output  N  quotient, held until next result
r  output  N  remainder, held until next result
div_by_zero  output  1  set with done when b==0, held with q/r

Behaviour:
- Reset (async assert, any state): state=S_IDLE; busy=0, done=0, q=0, r=0, div_by_zero=0; working regs and counter cleared. Aborts any in-flight operation, and no done is produced for it.
- States: S_IDLE, S_RUN, S_DONE.
  - S_IDLE: start=1 -> latch a, b; partial remainder=0; counter=N.
    - b!=0 -> S_RUN.
    - b==0 -> S_DONE (fast path).
  - S_RUN: one iteration per cycle: rem = {rem[N-2:0], dividend MSB}; shift dividend left; trial = rem - b (N+1 bits).
    - trial non-negative -> rem=trial, quotient bit=1.
    - Otherwise -> restore, bit=0.
    - Counter decrements; after the Nth iteration -> S_DONE.
  - S_DONE: done=1 for exactly this cycle; busy=0.
    - start=1 -> accepted as in S_IDLE (back-to-back).
    - Otherwise -> S_IDLE.
- Timing: start sampled at edge 0 -> RUN during cycles 1..N -> done high in cycle N+1 (N=4: cycle 5). With b==0, done is high in cycle 1.
- q, r, div_by_zero are registered outputs. They update only on entry to S_DONE and are otherwise held, including through S_IDLE and the whole of the next S_RUN.
- b==0 result: q = all ones, r = a, div_by_zero=1.
- b!=0 result: div_by_zero=0; q*b + r == a and r < b.
- busy = (state==S_RUN), registered or state-decoded; it must never be high together with done.
- start while busy=1: ignored; operands are not resampled.
- a, b may change freely after start is accepted without affecting the result.
- No X propagation: all state and working registers are reset.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] state_t {S_IDLE, S_RUN, S_DONE}.
  - Function cnt_w(N) = $clog2(N+1), used for the counter width.
- Sub-module div_step (combinational, parameter N):
  - Inputs: rem_in[N-1:0], dividend_msb, divisor[N-1:0].
  - Outputs: rem_out[N-1:0], q_bit.
  - Performs the shift / trial subtract / restore.
  - div_seq instantiates it once and handles registers, counter and FSM.

Test Plan:
- Basic divide, N=4: a=13, b=3, start pulsed 1 cycle -> busy cycles 1-4; done only in cycle 5 with q=4, r=1, div_by_zero=0; q/r held afterwards.
- Dividend smaller than divisor: a=7, b=9 -> q=0, r=7. Identity case: a=15, b=1 -> q=15, r=0. Each completes in 5 cycles.
- Divide by zero: a=9, b=0 -> done in cycle 1 with q=15, r=9, div_by_zero=1. A following 8/2 -> q=4, r=0, div_by_zero=0.
- Handshake robustness:
  - start held high through RUN with a/b changed mid-operation -> original result delivered, one done pulse.
  - start high in the done cycle -> new operation begins immediately (back-to-back, no idle cycle).
- Reset mid-operation: assert reset asynchronously in cycle 2 of 13/3 -> outputs go 0 immediately and no done follows. A new 6/4 after release -> q=1, r=2.
- Exhaustive, N=4: all 256 (a,b) pairs, back-to-back. For b!=0 check q*b+r==a and r<b; for b==0 check q=15, r=a, div_by_zero=1. Also check exactly one done per accepted start.
